// File: rtl/aes_gcm_pkg.sv
// aes_gcm_pkg: shared widths, FSM encoding and GCM helpers for the counter-mode controller.
// The E(K,J0) precompute in the top is enabled by defining AES_GCM_CTR_EK0_EN.
package aes_gcm_pkg;
  localparam int RND_SIZE = 128;
  localparam int CTR_SIZE = 32;
  localparam int BYTE_W   = 4;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_EK0     = 3'd1;
  localparam logic [2:0] ST_WAIT_PT = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;
  // Only the low counter field advances; the upper bits never see a carry.
  function automatic logic [RND_SIZE-1:0] inc32(input logic [RND_SIZE-1:0] b);
    return {b[RND_SIZE-1:CTR_SIZE], CTR_SIZE'(b[CTR_SIZE-1:0] + 1'b1)};
  endfunction
  // Byte 0 sits in the MSBs; a count of 0 means all 16 bytes are valid.
  function automatic logic [RND_SIZE-1:0] byte_mask(input logic [BYTE_W-1:0] n);
    return (n == '0) ? '1 : ~({RND_SIZE{1'b1}} >> (8 * n));
  endfunction
endpackage

// File: rtl/aes_gcm_byte_mask.sv
// aes_gcm_byte_mask: keep-mask for a block; only a final block can be partial.
module aes_gcm_byte_mask
  import aes_gcm_pkg::*;
(
  input  logic                last_i,
  input  logic [BYTE_W-1:0]   bytes_i,
  output logic [RND_SIZE-1:0] mask_o
);
  assign mask_o = last_i ? byte_mask(bytes_i) : '1;
endmodule

// File: rtl/aes_gcm_ctr_ctrl.sv
// aes_gcm_ctr_ctrl: GCM counter-mode sequencer around aes_data_path, one block in flight.
// Define AES_GCM_CTR_EK0_EN to also compute E(K,J0) before the first block.
module aes_gcm_ctr_ctrl
  import aes_gcm_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [RND_SIZE-1:0] i_key,
  input  logic [RND_SIZE-1:0] i_j0,
  input  logic                i_pt_valid,
  input  logic [RND_SIZE-1:0] i_pt_data,
  input  logic                i_pt_last,
  input  logic [BYTE_W-1:0]   i_pt_bytes,
  output logic                o_pt_ready,
  output logic                o_ct_valid,
  output logic [RND_SIZE-1:0] o_ct_data,
  output logic                o_ct_last,
  input  logic                i_ct_ready,
  output logic                o_dp_en,
  output logic [RND_SIZE-1:0] o_dp_text,
  output logic [RND_SIZE-1:0] o_dp_key,
  input  logic                i_dp_flag,
  input  logic [RND_SIZE-1:0] i_dp_cypher,
  output logic [RND_SIZE-1:0] o_ek0,
  output logic                o_ek0_valid,
  output logic                o_busy,
  output logic                o_done
);
  logic [2:0]          state_q, state_d;
  logic [RND_SIZE-1:0] key_q, key_d, ctr_q, ctr_d, pt_q, pt_d, ct_q, ct_d, mask;
  logic [BYTE_W-1:0]   bytes_q, bytes_d;
  logic                last_q, last_d, done_q, done_d;
  aes_gcm_byte_mask u_mask (.last_i(last_q), .bytes_i(bytes_q), .mask_o(mask));
`ifdef AES_GCM_CTR_EK0_EN
  logic [RND_SIZE-1:0] j0_q, j0_d, ek0_q, ek0_d;
  logic                ek0_valid_q, ek0_valid_d;
`endif
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    ctr_d   = ctr_q;
    pt_d    = pt_q;
    ct_d    = ct_q;
    bytes_d = bytes_q;
    last_d  = last_q;
    done_d  = 1'b0;
`ifdef AES_GCM_CTR_EK0_EN
    j0_d        = j0_q;
    ek0_d       = ek0_q;
    ek0_valid_d = ek0_valid_q;
`endif
    case (state_q)
      ST_IDLE: if (i_start) begin
        key_d = i_key;
        ctr_d = inc32(i_j0);
`ifdef AES_GCM_CTR_EK0_EN
        j0_d        = i_j0;
        ek0_valid_d = 1'b0;
        state_d     = ST_EK0;
`else
        state_d = ST_WAIT_PT;
`endif
      end
`ifdef AES_GCM_CTR_EK0_EN
      ST_EK0: if (i_dp_flag) begin
        ek0_d       = i_dp_cypher;
        ek0_valid_d = 1'b1;
        state_d     = ST_WAIT_PT;
      end
`endif
      ST_WAIT_PT: if (i_pt_valid) begin
        pt_d    = i_pt_data;
        last_d  = i_pt_last;
        bytes_d = i_pt_bytes;
        state_d = ST_RUN;
      end
      ST_RUN: if (i_dp_flag) begin
        ct_d    = (pt_q ^ i_dp_cypher) & mask;
        ctr_d   = inc32(ctr_q);
        state_d = ST_HOLD;
      end
      ST_HOLD: if (i_ct_ready) begin
        done_d  = last_q;
        state_d = last_q ? ST_IDLE : ST_WAIT_PT;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      ctr_q   <= '0;
      pt_q    <= '0;
      ct_q    <= '0;
      bytes_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      ctr_q   <= ctr_d;
      pt_q    <= pt_d;
      ct_q    <= ct_d;
      bytes_q <= bytes_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end
`ifdef AES_GCM_CTR_EK0_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      j0_q        <= '0;
      ek0_q       <= '0;
      ek0_valid_q <= 1'b0;
    end else begin
      j0_q        <= j0_d;
      ek0_q       <= ek0_d;
      ek0_valid_q <= ek0_valid_d;
    end
  end
  assign o_dp_text   = (state_q == ST_RUN) ? ctr_q : (state_q == ST_EK0) ? j0_q : '0;
  assign o_ek0       = ek0_q;
  assign o_ek0_valid = ek0_valid_q;
`else
  assign o_dp_text   = (state_q == ST_RUN) ? ctr_q : '0;
  assign o_ek0       = '0;
  assign o_ek0_valid = 1'b0;
`endif
  assign o_dp_en    = (state_q == ST_RUN) || (state_q == ST_EK0);
  assign o_dp_key   = key_q;
  assign o_pt_ready = state_q == ST_WAIT_PT;
  assign o_ct_valid = state_q == ST_HOLD;
  assign o_ct_data  = ct_q;
  assign o_ct_last  = o_ct_valid & last_q;
  assign o_busy     = state_q != ST_IDLE;
  assign o_done     = done_q;
endmodule

// File: tb/tb_aes_gcm_ctr_ctrl.sv
// tb_aes_gcm_ctr_ctrl: directed vectors against a stub data path with a fixed 4-cycle latency.
// The stub returns the real AES-128 results for K=0 (J0=1, J0+1) and a simple mix otherwise.
module tb_aes_gcm_ctr_ctrl;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_start, i_pt_valid, i_pt_last, i_ct_ready;
  logic [127:0] i_key, i_j0, i_pt_data;
  logic [3:0]   i_pt_bytes;
  logic         o_pt_ready, o_ct_valid, o_ct_last, o_dp_en, o_ek0_valid, o_busy, o_done;
  logic [127:0] o_ct_data, o_dp_text, o_dp_key, o_ek0;
  logic         dp_flag = 1'b0;
  logic [127:0] dp_cypher = '0;
  int           dp_cnt = 0;
  logic [127:0] tq[$];
  logic [127:0] kq[$];
  int           errors = 0;
  int           checks = 0;

  localparam logic [127:0] MIX = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] K2  = 128'hfeffe9928665731c6d6a8f9467308308;
  localparam logic [127:0] K3  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [95:0]  U   = 96'hcafebabefacedbaddecaf888;
  localparam logic [127:0] M5  = 128'hffffffffff0000000000000000000000;

  aes_gcm_ctr_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_key(i_key), .i_j0(i_j0),
    .i_pt_valid(i_pt_valid), .i_pt_data(i_pt_data), .i_pt_last(i_pt_last),
    .i_pt_bytes(i_pt_bytes), .o_pt_ready(o_pt_ready), .o_ct_valid(o_ct_valid),
    .o_ct_data(o_ct_data), .o_ct_last(o_ct_last), .i_ct_ready(i_ct_ready),
    .o_dp_en(o_dp_en), .o_dp_text(o_dp_text), .o_dp_key(o_dp_key),
    .i_dp_flag(dp_flag), .i_dp_cypher(dp_cypher), .o_ek0(o_ek0),
    .o_ek0_valid(o_ek0_valid), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ks(input logic [127:0] k, input logic [127:0] t);
    if (k == '0 && t == 128'h1) return 128'h58e2fccefa7e3061367f1d57a4e7455a;
    if (k == '0 && t == 128'h2) return 128'h0388dace60b6a392f328c2b971b2fe78;
    return t ^ k ^ MIX;
  endfunction

  always @(posedge clk) begin
    if (o_dp_en && !dp_flag && dp_cnt == 0) begin
      tq.push_back(o_dp_text);
      kq.push_back(o_dp_key);
    end
    dp_flag   <= o_dp_en && !dp_flag && dp_cnt == 2;
    dp_cypher <= ks(o_dp_key, o_dp_text);
    dp_cnt    <= (o_dp_en && !dp_flag) ? dp_cnt + 1 : 0;
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic pop_run(input string tag, input logic [127:0] exp_text, input logic [127:0] exp_key);
    if (tq.size() == 0) chk({tag, "_no_run"}, 0, 1);
    else begin
      chk({tag, "_text"}, tq.pop_front(), exp_text);
      chk({tag, "_key"}, kq.pop_front(), exp_key);
    end
  endtask

  task automatic start_msg(input logic [127:0] k, input logic [127:0] j0, input logic [127:0] ek0_exp);
    int n;
    @(negedge clk);
    i_start = 1'b1; i_key = k; i_j0 = j0;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("busy_after_start", o_busy, 1);
`ifdef AES_GCM_CTR_EK0_EN
    chk("ek0_valid_cleared", o_ek0_valid, 0);
    n = 0;
    while (!o_ek0_valid && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("ek0_timeout", 0, 1);
    chk("ek0", o_ek0, ek0_exp);
    pop_run("ek0_run", j0, k);
`else
    chk("ek0_off", o_ek0, 0);
    chk("ek0_valid_off", o_ek0_valid, {127'b0, ek0_exp[0] & 1'b0});
`endif
  endtask

  task automatic send_block(input logic [127:0] pt, input logic last, input logic [3:0] nb, input int stall,
                            input logic [127:0] exp_text, input logic [127:0] exp_key, input logic [127:0] exp_ct);
    int n;
    int bad;
    logic [127:0] ct;
    @(negedge clk);
    i_pt_valid = 1'b1; i_pt_data = pt; i_pt_last = last; i_pt_bytes = nb;
    n = 0;
    while (!o_pt_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("pt_ready_timeout", 0, 1);
    @(posedge clk); #1;
    i_pt_valid = 1'b0;
    chk("dp_en_after_accept", o_dp_en, 1);
    n = 0;
    while (!o_ct_valid && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("ct_valid_timeout", 0, 1);
    @(negedge clk);
    ct = o_ct_data;
    chk("ct_data", ct, exp_ct);
    chk("ct_last", o_ct_last, last);
    pop_run("run", exp_text, exp_key);
    bad = 0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (o_ct_valid !== 1'b1 || o_ct_data !== ct || o_pt_ready !== 1'b0 || o_dp_en !== 1'b0) bad++;
    end
    if (stall > 0) chk("stall_hold", bad, 0);
    i_ct_ready = 1'b1;
    @(posedge clk); #1;
    i_ct_ready = 1'b0;
    chk("done", o_done, last);
    chk("ct_valid_drop", o_ct_valid, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", o_done, 0);
  endtask

  initial begin
    logic [127:0] p1, p2, p3, pa, pb, pp;
    int n;
    p1 = 128'hd9313225f88406e5a55909c5aff5269a;
    p2 = 128'h86a7a9531534f7da2e4c303d8a318a72;
    p3 = 128'h1c3c0c95956809532fcf0e2449a6b525;
    pa = 128'h0123456789abcdeffedcba9876543210;
    pb = 128'h5555aaaa5555aaaa0000ffff0000ffff;
    pp = 128'h00112233445566778899aabbccddeeff;
    rst_n = 1'b0; i_start = 1'b0; i_key = '0; i_j0 = '0;
    i_pt_valid = 1'b0; i_pt_data = '0; i_pt_last = 1'b0; i_pt_bytes = '0; i_ct_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_pt_ready", o_pt_ready, 0);
    chk("rst_ct_valid", o_ct_valid, 0);
    chk("rst_dp_en", o_dp_en, 0);
    chk("rst_dp_key", o_dp_key, 0);
    chk("rst_ct_data", o_ct_data, 0);
    chk("rst_ek0_valid", o_ek0_valid, 0);
    chk("rst_done", o_done, 0);
    rst_n = 1'b1;

    // Known AES-128 vector: K=0, J0=1, single zero block
    start_msg('0, 128'h1, 128'h58e2fccefa7e3061367f1d57a4e7455a);
    send_block('0, 1'b1, 4'd0, 0, 128'h2, '0, 128'h0388dace60b6a392f328c2b971b2fe78);
    chk("idle_after_msg", o_busy, 0);

    // Counter wrap; first block's byte count must be ignored (not last)
    start_msg(K2, {U, 32'hfffffffe}, ks(K2, {U, 32'hfffffffe}));
    send_block(p1, 1'b0, 4'd5, 0, {U, 32'hffffffff}, K2, p1 ^ ks(K2, {U, 32'hffffffff}));
    send_block(p2, 1'b0, 4'd0, 0, {U, 32'h00000000}, K2, p2 ^ ks(K2, {U, 32'h00000000}));
    send_block(p3, 1'b1, 4'd0, 0, {U, 32'h00000001}, K2, p3 ^ ks(K2, {U, 32'h00000001}));

    // Partial final block (5 bytes) with a 20-cycle downstream stall
    start_msg(K2, 128'h7, ks(K2, 128'h7));
    send_block(pp, 1'b1, 4'd5, 20, 128'h8, K2, (pp ^ ks(K2, 128'h8)) & M5);

    // Reset in the middle of a run
    start_msg(K3, {96'habc, 32'h20}, ks(K3, {96'habc, 32'h20}));
    @(negedge clk);
    i_pt_valid = 1'b1; i_pt_data = pa; i_pt_last = 1'b1; i_pt_bytes = 4'd0;
    n = 0;
    while (!o_pt_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("rst_pt_ready_timeout", 0, 1);
    @(posedge clk); #1;
    i_pt_valid = 1'b0;
    chk("rst_test_dp_en", o_dp_en, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_dp_en", o_dp_en, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_dp_key", o_dp_key, 0);
    chk("midrst_dp_text", o_dp_text, 0);
    chk("midrst_ct_data", o_ct_data, 0);
    chk("midrst_ek0_valid", o_ek0_valid, 0);
    rst_n = 1'b1;
    pop_run("midrst_run", {96'habc, 32'h21}, K3);

    // i_start while busy must not disturb key or counter
    start_msg(K2, {96'h77, 32'h10}, ks(K2, {96'h77, 32'h10}));
    send_block(pa, 1'b0, 4'd0, 0, {96'h77, 32'h11}, K2, pa ^ ks(K2, {96'h77, 32'h11}));
    @(negedge clk);
    i_start = 1'b1; i_key = K3; i_j0 = '0;
    @(posedge clk); #1;
    i_start = 1'b0;
    chk("busy_start_ignored", o_busy, 1);
    chk("busy_start_pt_ready", o_pt_ready, 1);
    send_block(pb, 1'b1, 4'd0, 0, {96'h77, 32'h12}, K2, pb ^ ks(K2, {96'h77, 32'h12}));
    chk("final_idle", o_busy, 0);
    chk("no_extra_runs", tq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
